// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Free-running VGA timing generator. A clock divider produces a pixel tick
//   every CLK_DIV clk cycles. Each tick advances a horizontal/vertical
//   position counter. Sync and blanking outputs are decoded from the
//   next-state position and registered, so they change on the same clk edge
//   as the position outputs.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           advance enable; low freezes every counter and output
//   pixel_tick   one-clk pulse on cycles where the position advances at the next edge
//   pixel_x      current horizontal count, 0..H_TOTAL-1
//   pixel_y      current vertical count, 0..V_TOTAL-1
//   hsync        horizontal sync, SYNC_POL polarity
//   vsync        vertical sync, SYNC_POL polarity
//   video_on     inside the visible window
//   frame_start  one-clk pulse in the cycle after position (0,0) is entered
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_q, video_d;
  logic          fstart_q, fstart_d;
  logic          tick;

  always_comb begin
    tick     = en && (div_q == DIV_LAST);
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;

    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    // Vertical count only moves on the tick that wraps the line.
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Decoding the next-state counts keeps these aligned with pixel_x/y.
    hsync_d  = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    video_d  = (h_d < H_VIS) && (v_d < V_VIS);
    fstart_d = tick && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      h_q      <= H_LAST;
      v_q      <= V_LAST;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      video_q  <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
      fstart_q <= fstart_d;
    end
  end

  assign pixel_tick  = tick;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  // Frame pulse is suppressed while frozen so a stalled frame start never
  // appears to last more than one active cycle.
  assign frame_start = fstart_q & en;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Three instances: default 640x480 timing, a small active-low geometry with
//   CLK_DIV=2, and the same small geometry active-high with CLK_DIV=3.
//   A reference model derives the expected position from the number of
//   enabled clk edges since reset and pushes per-edge expectations to queues;
//   a checker pops them one time unit after each rising edge.
module tb_vga_sync_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  logic       tk_d, hs_d, vs_d, vid_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       tk_a, hs_a, vs_a, vid_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       tk_b, hs_b, vs_b, vid_b, fs_b;
  logic [9:0] x_b, y_b;

  vga_sync_gen dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(tk_d),
    .pixel_x(x_d), .pixel_y(y_d), .hsync(hs_d), .vsync(vs_d),
    .video_on(vid_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(tk_a),
    .pixel_x(x_a), .pixel_y(y_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vid_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(3), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_tick(tk_b),
    .pixel_x(x_b), .pixel_y(y_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(vid_b), .frame_start(fs_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [24:0] exp_d_q[$];
  logic [24:0] exp_a_q[$];
  logic [24:0] exp_b_q[$];

  int ecount = 0;   // enabled clk edges since reset
  bit adv    = 1'b0; // last edge was an enabled, non-reset edge

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Expected {tick, x, y, hsync, vsync, video_on, frame_start}.
  function automatic logic [24:0] exp_vec(input int ht, input int vt, input int hd, input int hf,
                                          input int hsw, input int vd, input int vf, input int vsw,
                                          input int dv, input bit pol, input int ec,
                                          input bit en_now, input bit adv_now);
    int n, p, x, y;
    bit tk, hsa, vsa, vid, fs;
    tk = en_now && ((ec % dv) == dv - 1);
    n  = ec / dv;
    if (n == 0) begin
      x = ht - 1; y = vt - 1; hsa = 1'b0; vsa = 1'b0; vid = 1'b0; fs = 1'b0;
    end else begin
      p   = (n - 1) % (ht * vt);
      x   = p % ht;
      y   = p / ht;
      hsa = (x >= hd + hf) && (x < hd + hf + hsw);
      vsa = (y >= vd + vf) && (y < vd + vf + vsw);
      vid = (x < hd) && (y < vd);
      fs  = en_now && adv_now && ((ec % dv) == 0) && (p == 0);
    end
    return {tk, x[9:0], y[9:0], hsa ? pol : !pol, vsa ? pol : !pol, vid, fs};
  endfunction

  // Reference model: update on each rising edge and queue expectations.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ecount = 0;
        adv    = 1'b0;
      end else if (en) begin
        ecount++;
        adv = 1'b1;
      end else begin
        adv = 1'b0;
      end
      exp_d_q.push_back(exp_vec(800, 525, 640, 16, 96, 480, 10, 2, 2, 1'b0, ecount, en, adv));
      exp_a_q.push_back(exp_vec(15, 8, 8, 2, 3, 4, 1, 2, 2, 1'b0, ecount, en, adv));
      exp_b_q.push_back(exp_vec(15, 8, 8, 2, 3, 4, 1, 2, 3, 1'b1, ecount, en, adv));
    end
  end

  // Scoreboard: compare one time unit after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_d_q.size() > 0)
        check_val("sb_dut_d", {tk_d, x_d, y_d, hs_d, vs_d, vid_d, fs_d}, exp_d_q.pop_front());
      if (exp_a_q.size() > 0)
        check_val("sb_dut_a", {tk_a, x_a, y_a, hs_a, vs_a, vid_a, fs_a}, exp_a_q.pop_front());
      if (exp_b_q.size() > 0)
        check_val("sb_dut_b", {tk_b, x_b, y_b, hs_b, vs_b, vid_b, fs_b}, exp_b_q.pop_front());
    end
  end

  task automatic check_reset_values(input string tag);
    check_val({tag, "_x_d"},  32'(x_d), 32'd799);
    check_val({tag, "_y_d"},  32'(y_d), 32'd524);
    check_val({tag, "_hs_d"}, 32'(hs_d), 32'd1);
    check_val({tag, "_vs_d"}, 32'(vs_d), 32'd1);
    check_val({tag, "_vid_d"}, 32'(vid_d), 32'd0);
    check_val({tag, "_fs_d"}, 32'(fs_d), 32'd0);
    check_val({tag, "_xy_a"}, {12'd0, x_a, y_a}, {12'd0, 10'd14, 10'd7});
    check_val({tag, "_hs_a"}, 32'(hs_a), 32'd1);
    check_val({tag, "_hs_b"}, 32'(hs_b), 32'd0);
    check_val({tag, "_vs_b"}, 32'(vs_b), 32'd0);
  endtask

  // Driver
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("rst_hold");

    // Release: first edge only advances the divider, second enters (0,0).
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_val("rel_e1_x", 32'(x_d), 32'd799);
    check_val("rel_e1_tick", 32'(tk_d), 32'd1);
    @(posedge clk); #2;
    check_val("rel_e2_xy", {12'd0, x_d, y_d}, 32'd0);
    check_val("rel_e2_vid", 32'(vid_d), 32'd1);
    check_val("rel_e2_fs", 32'(fs_d), 32'd1);
    @(posedge clk); #2;
    check_val("rel_e3_fs", 32'(fs_d), 32'd0);

    // Free run: a few small frames and the first full default line.
    repeat (3000) @(negedge clk);

    // Random enable pattern.
    repeat (2000) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
    end

    // Freeze for 10 clk.
    en = 1'b1;
    repeat (7) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (50) @(negedge clk);

    // Reset between edges while dut_a has its horizontal sync active.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hs_a == 1'b0) break;
    end
    check_val("pre_rst_hs_a_active", 32'(hs_a), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);

    @(posedge clk); #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
